// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and small decode helpers for the load/store unit.
package lsu_pkg;

  // RV32 load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // memory controller instr_mode encodings
  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_BYTE = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

  // access size is carried in funct3[1:0]; funct3[2] only selects unsigned loads
  function automatic logic [1:0] f3_to_mode(input logic [2:0] f3);
    logic [1:0] mode;
    case (f3[1:0])
      2'b00:   mode = MODE_BYTE;
      2'b01:   mode = MODE_HALF;
      default: mode = MODE_WORD;
    endcase
    return mode;
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of zero-filled controller read data.
// Ports: i_funct3 - load funct3; i_data - raw controller data (low bytes valid);
//        o_data_c - extended result (combinational).
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_data,
  output logic [31:0] o_data_c
);

  always_comb begin
    o_data_c = i_data;
    case (i_funct3)
      F3_B:    o_data_c = {{24{i_data[7]}}, i_data[7:0]};
      F3_BU:   o_data_c = {24'h0, i_data[7:0]};
      F3_H:    o_data_c = {{16{i_data[15]}}, i_data[15:0]};
      F3_HU:   o_data_c = {16'h0, i_data[15:0]};
      default: o_data_c = i_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: validates one core request, drives the memory controller,
// waits for its done pulse (with timeout) and returns a one-cycle response.
// Ports: clk/rst_n (sync active-low); req_* core request channel;
//        resp_* one-cycle response; mem_* memory controller interface.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned ADDR_W         = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_fault,
  output logic              mem_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_instr_mode,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_op_r
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;

  logic        w_legal;
  logic        w_misaligned;
  logic [1:0]  w_mode;
  logic [31:0] w_ext;

  // request decode, only meaningful while IDLE
  always_comb begin
    w_legal      = f3_legal(req_we, req_funct3);
    w_mode       = f3_to_mode(req_funct3);
    w_misaligned = 1'b0;
    if (w_legal) begin
      if (w_mode == MODE_HALF)      w_misaligned = req_addr[0];
      else if (w_mode == MODE_WORD) w_misaligned = (req_addr[1:0] != 2'b00);
    end
  end

  load_extend u_ext (
    .i_funct3 (r_funct3),
    .i_data   (mem_rdata),
    .o_data_c (w_ext)
  );

  // control FSM; all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_funct3        <= 3'b000;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
      mem_enable      <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= 32'h0;
      mem_instr_mode  <= 2'b00;
    end else begin
      mem_enable <= 1'b0;
      resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            r_funct3  <= req_funct3;
            if (!w_legal || w_misaligned) begin
              // rejected without touching the controller
              r_state         <= RESP;
              resp_valid      <= 1'b1;
              resp_rdata      <= 32'h0;
              resp_fault      <= !w_legal;
              resp_misaligned <= w_misaligned;
            end else begin
              // mem_* stay frozen until the response; controller samples late
              r_state        <= ISSUE;
              mem_enable     <= 1'b1;
              mem_we         <= req_we;
              mem_addr       <= req_addr;
              mem_wdata      <= req_wdata;
              mem_instr_mode <= w_mode;
            end
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // done pulse takes priority over a coincident timeout
          if (mem_op_r) begin
            r_state         <= RESP;
            resp_valid      <= 1'b1;
            resp_rdata      <= mem_we ? 32'h0 : w_ext;
            resp_fault      <= 1'b0;
            resp_misaligned <= 1'b0;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_state         <= RESP;
            resp_valid      <= 1'b1;
            resp_rdata      <= 32'h0;
            resp_fault      <= 1'b1;
            resp_misaligned <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_state         <= IDLE;
          req_ready       <= 1'b1;
          resp_rdata      <= 32'h0;
          resp_fault      <= 1'b0;
          resp_misaligned <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 4-cycle memory controller model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid, resp_misaligned, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_enable, mem_we, mem_op_r;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_instr_mode;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(15), .ADDR_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_enable(mem_enable), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_instr_mode(mem_instr_mode),
    .mem_rdata(mem_rdata), .mem_op_r(mem_op_r)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
  } exp_t;
  exp_t sb[$];

  // response monitor: every resp_valid must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_misaligned", {31'd0, resp_misaligned}, {31'd0, e.mis});
        check("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
      end
    end
  end

  int en_cnt = 0;
  always @(negedge clk) if (mem_enable) en_cnt++;

  // memory controller model: 4-cycle access, zero-filled reads
  logic [7:0]  mem [0:255];
  logic        busy = 1'b0, saw_rst = 1'b0, stub_mute = 1'b0;
  int unsigned mcnt = 0;
  logic [23:0] l_addr;
  logic        l_we;
  logic [1:0]  l_mode;
  logic [31:0] l_wdata;

  always @(posedge clk) begin
    logic [7:0] a;
    mem_op_r <= 1'b0;
    if (busy && mem_enable) check("enable_while_busy", 32'd1, 32'd0);
    if (busy) begin
      if (!rst_n) saw_rst <= 1'b1;
      if (mcnt == 3) begin
        busy <= 1'b0;
        if (!saw_rst && rst_n) begin
          check("stable_addr", {8'd0, mem_addr}, {8'd0, l_addr});
          check("stable_we", {31'd0, mem_we}, {31'd0, l_we});
          check("stable_mode", {30'd0, mem_instr_mode}, {30'd0, l_mode});
        end
        a = l_addr[7:0];
        if (l_we) begin
          mem[a] <= l_wdata[7:0];
          if (l_mode != 2'b01) mem[8'(a + 8'd1)] <= l_wdata[15:8];
          if (l_mode == 2'b00) begin
            mem[8'(a + 8'd2)] <= l_wdata[23:16];
            mem[8'(a + 8'd3)] <= l_wdata[31:24];
          end
          mem_rdata <= 32'h0;
        end else begin
          case (l_mode)
            2'b01:   mem_rdata <= {24'h0, mem[a]};
            2'b10:   mem_rdata <= {16'h0, mem[8'(a + 8'd1)], mem[a]};
            default: mem_rdata <= {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)],
                                   mem[8'(a + 8'd1)], mem[a]};
          endcase
        end
        if (!stub_mute) mem_op_r <= 1'b1;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else if (mem_enable) begin
      busy    <= 1'b1;
      saw_rst <= 1'b0;
      mcnt    <= 0;
      l_addr  <= mem_addr;
      l_we    <= mem_we;
      l_mode  <= mem_instr_mode;
      l_wdata <= mem_wdata;
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // issue one request, queue its expected response, wait for it to drain
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [23:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_mis,
                        input logic exp_fault, input int exp_en);
    exp_t e;
    int k;
    @(negedge clk);
    wait_ready();
    en_cnt = 0;
    e.rdata = exp_rdata; e.mis = exp_mis; e.fault = exp_fault;
    sb.push_back(e);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check({tag, "_no_resp"}, 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
    check({tag, "_enables"}, 32'(en_cnt), 32'(exp_en));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hb3; mem[1] = 8'h50; mem[2] = 8'h31; mem[3] = 8'h40;
    mem_rdata = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 24'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", {8'd0, mem_addr}, 32'h0);
    rst_n = 1'b1;

    // loads from preloaded bytes
    do_req("lw0",  1'b0, 3'b010, 24'd0, 32'h0, 32'h403150b3, 1'b0, 1'b0, 1);
    do_req("lb0",  1'b0, 3'b000, 24'd0, 32'h0, 32'hffffffb3, 1'b0, 1'b0, 1);
    do_req("lbu0", 1'b0, 3'b100, 24'd0, 32'h0, 32'h000000b3, 1'b0, 1'b0, 1);
    do_req("lh2",  1'b0, 3'b001, 24'd2, 32'h0, 32'h00004031, 1'b0, 1'b0, 1);
    // store then read back
    do_req("sw8",   1'b1, 3'b010, 24'd8,  32'hdeadbeef, 32'h0, 1'b0, 1'b0, 1);
    do_req("lw8",   1'b0, 3'b010, 24'd8,  32'h0, 32'hdeadbeef, 1'b0, 1'b0, 1);
    do_req("lh8",   1'b0, 3'b001, 24'd8,  32'h0, 32'hffffbeef, 1'b0, 1'b0, 1);
    do_req("lhu10", 1'b0, 3'b101, 24'd10, 32'h0, 32'h0000dead, 1'b0, 1'b0, 1);
    do_req("sb12",  1'b1, 3'b000, 24'd12, 32'h123456a5, 32'h0, 1'b0, 1'b0, 1);
    do_req("lw12",  1'b0, 3'b010, 24'd12, 32'h0, 32'h000000a5, 1'b0, 1'b0, 1);
    // misaligned: no controller access
    do_req("mis_lw5", 1'b0, 3'b010, 24'd5, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    do_req("mis_lh3", 1'b0, 3'b001, 24'd3, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    do_req("mis_sh1", 1'b1, 3'b001, 24'd1, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    // illegal funct3
    do_req("ill_ld3", 1'b0, 3'b011, 24'd0, 32'h0, 32'h0, 1'b0, 1'b1, 0);
    do_req("ill_st4", 1'b1, 3'b100, 24'd0, 32'h0, 32'h0, 1'b0, 1'b1, 0);
    // controller that never answers
    stub_mute = 1'b1;
    do_req("tmo", 1'b0, 3'b010, 24'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    stub_mute = 1'b0;
    do_req("after_tmo", 1'b0, 3'b010, 24'd8, 32'h0, 32'hdeadbeef, 1'b0, 1'b0, 1);

    // reset while waiting on the controller: no response expected
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 24'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_wait_ready", {31'd0, req_ready}, 32'd1);
    check("rst_wait_no_resp", {31'd0, resp_valid}, 32'd0);
    repeat (10) @(negedge clk);
    check("rst_wait_idle", {31'd0, req_ready}, 32'd1);
    do_req("lw0_after_rst", 1'b0, 3'b010, 24'd0, 32'h0, 32'h403150b3, 1'b0, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
